hll_job_controller: RTL and testbench
=====================================

Name: hll_job_controller

Overview:
- Sequences HyperLogLog cardinality jobs for the hll core and DMA engine.
- Accepts a job descriptor (source address, byte length, result address) and splits the source read into DMA read commands of at most MAX_BURST bytes.
- Counts 512-bit input beats, generates TLAST on the final beat, waits for the core's result write, then reports completion with an elapsed-cycle count.
- Sits between the host control-register block and the hll core, replacing free-running beat counters with a one-job-at-a-time scheduler.

Parameters:
- MAX_BURST, 4096, maximum bytes per DMA read command; power of two, multiple of 64.
- BEAT_BYTES, 64, bytes per input beat; fixed by the 512-bit datapath.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- s_job_valid  in  1  job descriptor valid.
- s_job_ready  out  1  controller can accept a job.
- s_job_src_addr  in  64  DMA read source byte address.
- s_job_length  in  32  job length in bytes.
- s_job_dst_addr  in  64  result write base address.
- m_rd_cmd_valid  out  1  DMA read command valid.
- m_rd_cmd_ready  in  1  DMA read command accepted.
- m_rd_cmd_addr  out  64  read command address.
- m_rd_cmd_length  out  32  read command bytes.
- data_fire  in  1  input-stream beat handshake (valid & ready at the core input).
- data_enable  out  1  top level ANDs this into the input valid and ready.
- data_last  out  1  TLAST to the core input.
- hll_base_addr  out  64  result base address driven to the core; held for the whole job.
- wr_cmd_fire  in  1  core write-command handshake.
- wr_last_fire  in  1  core write-data handshake carrying TLAST.
- m_done_valid  out  1  completion valid.
- m_done_ready  in  1  completion accepted.
- m_done_cycles  out  32  cycles from job acceptance to result written.
- m_done_error  out  1  job rejected for illegal length.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rstn low) values:
  - state = IDLE.
  - All outputs 0, except s_job_ready = 1.
  - All counters and registers 0.
- States: IDLE, RUN, WAIT_WR, DONE.
- IDLE:
  - s_job_ready = 1.
  - On s_job_valid & s_job_ready, latch the descriptor and clear cyc_cnt.
  - If length == 0 or length[5:0] != 0: set err = 1 and go to DONE. No read command is issued and data_enable stays 0.
  - Otherwise: beats_total = length >> 6, rd_remaining = length, rd_addr = src_addr, beat_cnt = 0, go to RUN.
- RUN, command issue (independent of data counting):
  - m_rd_cmd_valid = (rd_remaining != 0).
  - m_rd_cmd_length = min(rd_remaining, MAX_BURST).
  - On a command handshake: rd_addr += length, rd_remaining -= length.
  - Address, length and valid are registered and stable while valid is high and ready is low.
- RUN, data counting:
  - data_enable = (beat_cnt < beats_total).
  - beat_cnt increments on data_fire while data_enable is high.
  - data_last = data_enable & (beat_cnt == beats_total - 1). This output is combinational.
  - Move to WAIT_WR on a data_fire with data_last high and rd_remaining == 0. Command issue always completes before the last beat can arrive.
- WAIT_WR:
  - data_enable = 0.
  - Set sticky flags cmd_seen on wr_cmd_fire and last_seen on wr_last_fire. The two may arrive in either order or in the same cycle.
  - Either fire seen while still in RUN is also captured in its flag.
  - Leave for DONE in the cycle after both flags are set.
- DONE:
  - m_done_valid = 1; m_done_cycles and m_done_error are held.
  - On m_done_ready: clear the flags and go to IDLE. The next job can be accepted in the following cycle.
- cyc_cnt:
  - Increments every cycle in RUN and WAIT_WR.
  - Saturates at 0xFFFF_FFFF.
  - Frozen on entry to DONE.
- hll_base_addr updates only on job acceptance.
- Jobs do not overlap; s_job_ready = 0 outside IDLE.
- Beats arriving when data_enable = 0 are blocked by top-level gating and must not change any counter.
- Reset asserted mid-job aborts it immediately:
  - All state clears and no done is reported.
  - Read commands already accepted by the DMA engine are not tracked.

Test Plan:
- Length 256 (4 beats), MAX_BURST 4096 -> one read command {addr = src, len = 256}; data_last on the 4th fire; after wr_cmd_fire and wr_last_fire, done with error = 0 and cycles equal to the measured count.
- Length 10240, MAX_BURST 4096, src 0x1000 -> read commands {0x1000, 4096}, {0x2000, 4096}, {0x3000, 2048}; 160 beats; data_last only on beat 160.
- m_rd_cmd_ready held low 5 cycles -> cmd valid/addr/length stable for those cycles; beats already issued keep counting.
- wr_last_fire 3 cycles before wr_cmd_fire, then a repeat with both in the same cycle -> done asserted exactly once per job, one cycle after the second event.
- Length 100, then length 0 -> no read command, done with error = 1, data_enable never high, back to IDLE after m_done_ready.
- rstn pulled low after 50 of 160 beats -> busy = 0 and s_job_ready = 1 immediately; a new 128-byte job then completes normally with data_last on its 2nd beat.

Source files
------------

// File: rtl/hll_job_controller_if.sv
// Handshake bundle between the host job queue, DMA read engine, hll core and the job controller.
// slave is the controller's view; master is the view of everything around it.
interface hll_job_controller_if;
  logic        s_job_valid;
  logic        s_job_ready;
  logic [63:0] s_job_src_addr;
  logic [31:0] s_job_length;
  logic [63:0] s_job_dst_addr;
  logic        m_rd_cmd_valid;
  logic        m_rd_cmd_ready;
  logic [63:0] m_rd_cmd_addr;
  logic [31:0] m_rd_cmd_length;
  logic        data_fire;
  logic        data_enable;
  logic        data_last;
  logic [63:0] hll_base_addr;
  logic        wr_cmd_fire;
  logic        wr_last_fire;
  logic        m_done_valid;
  logic        m_done_ready;
  logic [31:0] m_done_cycles;
  logic        m_done_error;
  logic        busy;

  modport slave (
    input  s_job_valid, s_job_src_addr, s_job_length, s_job_dst_addr,
    input  m_rd_cmd_ready, data_fire, wr_cmd_fire, wr_last_fire, m_done_ready,
    output s_job_ready, m_rd_cmd_valid, m_rd_cmd_addr, m_rd_cmd_length,
    output data_enable, data_last, hll_base_addr,
    output m_done_valid, m_done_cycles, m_done_error, busy
  );

  modport master (
    output s_job_valid, s_job_src_addr, s_job_length, s_job_dst_addr,
    output m_rd_cmd_ready, data_fire, wr_cmd_fire, wr_last_fire, m_done_ready,
    input  s_job_ready, m_rd_cmd_valid, m_rd_cmd_addr, m_rd_cmd_length,
    input  data_enable, data_last, hll_base_addr,
    input  m_done_valid, m_done_cycles, m_done_error, busy
  );
endinterface

// File: rtl/hll_job_controller.sv
// One-job-at-a-time scheduler for the HyperLogLog core: splits the source read into DMA bursts,
// counts input beats, raises TLAST, waits for the result write and reports elapsed cycles.
module hll_job_controller #(
  parameter int unsigned MAX_BURST  = 4096,
  parameter int unsigned BEAT_BYTES = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  hll_job_controller_if.slave  bus
);

  localparam int unsigned BEAT_SHIFT  = $clog2(BEAT_BYTES);
  localparam logic [31:0] BURST_BYTES = 32'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_WR, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_rd_addr;
  logic [63:0] r_base_addr;
  logic [31:0] r_rd_remaining;
  logic [31:0] r_beats_total;
  logic [31:0] r_beat_cnt;
  logic [31:0] r_cyc_cnt;
  logic        r_err;
  logic        r_cmd_seen;
  logic        r_last_seen;

  logic        w_accept;
  logic        w_len_bad;
  logic        w_rd_done;
  logic        w_cmd_valid;
  logic        w_cmd_fire;
  logic [31:0] w_cmd_len;
  logic        w_data_enable;
  logic        w_data_last;
  logic        w_beat;
  logic        w_active;
  logic        w_job_ready;
  logic        w_done_valid;
  logic        w_busy;

  assign w_len_bad     = (bus.s_job_length == 32'd0) ||
                         (bus.s_job_length[BEAT_SHIFT-1:0] != '0);
  assign w_accept      = bus.s_job_valid && (r_state == IDLE);
  assign w_rd_done     = (r_rd_remaining == 32'd0);
  assign w_cmd_valid   = (r_state == RUN) && !w_rd_done;
  assign w_cmd_len     = (r_rd_remaining > BURST_BYTES) ? BURST_BYTES : r_rd_remaining;
  assign w_cmd_fire    = w_cmd_valid && bus.m_rd_cmd_ready;
  assign w_data_enable = (r_state == RUN) && (r_beat_cnt < r_beats_total);
  assign w_data_last   = w_data_enable && (r_beat_cnt == r_beats_total - 32'd1);
  assign w_beat        = bus.data_fire && w_data_enable;
  assign w_active      = (r_state == RUN) || (r_state == WAIT_WR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The fallback RUN exit covers a last beat that arrived before the final read command was taken.
  always_comb begin
    w_next       = r_state;
    w_job_ready  = 1'b0;
    w_done_valid = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_job_ready = 1'b1;
        w_busy      = 1'b0;
        if (bus.s_job_valid) w_next = w_len_bad ? DONE : RUN;
      end
      RUN: begin
        if (bus.data_fire && w_data_last && w_rd_done) w_next = WAIT_WR;
        else if (!w_data_enable && w_rd_done)          w_next = WAIT_WR;
      end
      WAIT_WR: begin
        if (r_cmd_seen && r_last_seen) w_next = DONE;
      end
      DONE: begin
        w_done_valid = 1'b1;
        if (bus.m_done_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_addr      <= '0;
      r_base_addr    <= '0;
      r_rd_remaining <= '0;
      r_beats_total  <= '0;
      r_beat_cnt     <= '0;
      r_cyc_cnt      <= '0;
      r_err          <= 1'b0;
      r_cmd_seen     <= 1'b0;
      r_last_seen    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base_addr    <= bus.s_job_dst_addr;
        r_rd_addr      <= bus.s_job_src_addr;
        r_cyc_cnt      <= '0;
        r_beat_cnt     <= '0;
        r_err          <= w_len_bad;
        r_cmd_seen     <= 1'b0;
        r_last_seen    <= 1'b0;
        r_rd_remaining <= w_len_bad ? 32'd0 : bus.s_job_length;
        r_beats_total  <= w_len_bad ? 32'd0 : (bus.s_job_length >> BEAT_SHIFT);
      end
      if (w_cmd_fire) begin
        r_rd_addr      <= r_rd_addr + {32'd0, w_cmd_len};
        r_rd_remaining <= r_rd_remaining - w_cmd_len;
      end
      if (w_beat) r_beat_cnt <= r_beat_cnt + 32'd1;
      if (w_active && (r_cyc_cnt != 32'hFFFF_FFFF)) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_active) begin
        if (bus.wr_cmd_fire)  r_cmd_seen  <= 1'b1;
        if (bus.wr_last_fire) r_last_seen <= 1'b1;
      end
      if ((r_state == DONE) && bus.m_done_ready) begin
        r_cmd_seen  <= 1'b0;
        r_last_seen <= 1'b0;
      end
    end
  end

  assign bus.s_job_ready     = w_job_ready;
  assign bus.m_rd_cmd_valid  = w_cmd_valid;
  assign bus.m_rd_cmd_addr   = r_rd_addr;
  assign bus.m_rd_cmd_length = w_cmd_len;
  assign bus.data_enable     = w_data_enable;
  assign bus.data_last       = w_data_last;
  assign bus.hll_base_addr   = r_base_addr;
  assign bus.m_done_valid    = w_done_valid;
  assign bus.m_done_cycles   = r_cyc_cnt;
  assign bus.m_done_error    = r_err;
  assign bus.busy            = w_busy;

endmodule

// File: tb/tb_hll_job_controller.sv
// Randomized bench for hll_job_controller: a job-level model predicts read bursts, beat framing,
// completion timing and elapsed cycles; every cycle of each job is compared against it.
module tb_hll_job_controller;

  localparam int MAX_BURST = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   edgeCount  = 0;
  int   checkCount = 0;
  int   passCount  = 0;

  hll_job_controller_if bus();

  hll_job_controller #(.MAX_BURST(MAX_BURST), .BEAT_BYTES(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, edgeCount);
  endtask

  task automatic driveIdle();
    bus.s_job_valid    = 1'b0;
    bus.s_job_src_addr = '0;
    bus.s_job_length   = '0;
    bus.s_job_dst_addr = '0;
    bus.m_rd_cmd_ready = 1'b0;
    bus.data_fire      = 1'b0;
    bus.wr_cmd_fire    = 1'b0;
    bus.wr_last_fire   = 1'b0;
    bus.m_done_ready   = 1'b0;
  endtask

  // Runs one job from acceptance to completion handshake; entered and left on a falling edge.
  // kCmd/kLast place the core's write handshakes that many edges after the final beat's edge.
  task automatic applyStimulus(input logic [63:0] src, input logic [31:0] len, input logic [63:0] dst,
                               input int stallIdx, input int stallLen, input int kCmd, input int kLast,
                               input int abortAt);
    logic [63:0] qa[$];
    logic [31:0] ql[$];
    logic [63:0] a;
    logic [31:0] rem;
    logic [31:0] chunk;
    logic [31:0] heldCycles;
    bit   err;
    bit   finished;
    bit   expDone;
    int   beatsTotal;
    int   beatsDone;
    int   credit;
    int   cmdIdx;
    int   stallLeft;
    int   acceptEdge;
    int   lastEdge;
    int   doneEdge;
    int   guard;

    err = (len == 32'd0) || (len % 64 != 0);
    a   = src;
    rem = err ? 32'd0 : len;
    while (rem != 0) begin
      chunk = (rem > MAX_BURST) ? 32'(MAX_BURST) : rem;
      qa.push_back(a);
      ql.push_back(chunk);
      a   = a + 64'(chunk);
      rem = rem - chunk;
    end
    beatsTotal = err ? 0 : int'(len / 64);
    beatsDone  = 0;
    credit     = 0;
    cmdIdx     = 0;
    stallLeft  = stallLen;
    lastEdge   = -1;
    doneEdge   = -1;
    finished   = 1'b0;

    checkOutput("job_ready", 64'(bus.s_job_ready), 64'(1));
    bus.s_job_valid    = 1'b1;
    bus.s_job_src_addr = src;
    bus.s_job_length   = len;
    bus.s_job_dst_addr = dst;
    bus.data_fire      = 1'($urandom_range(0, 1));
    @(negedge clk);
    acceptEdge         = edgeCount;
    bus.s_job_valid    = 1'b0;
    bus.s_job_src_addr = {$urandom, $urandom};
    bus.s_job_length   = $urandom;
    bus.s_job_dst_addr = {$urandom, $urandom};
    if (err) doneEdge = acceptEdge;
    checkOutput("base_addr", bus.hll_base_addr, dst);
    checkOutput("busy", 64'(bus.busy), 64'(1));

    guard = 0;
    while (!finished && guard < 20000) begin
      guard++;
      if (abortAt >= 0 && beatsDone == abortAt) begin
        rstn = 1'b0;
        driveIdle();
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'(0));
        checkOutput("abort_job_ready", 64'(bus.s_job_ready), 64'(1));
        checkOutput("abort_data_enable", 64'(bus.data_enable), 64'(0));
        checkOutput("abort_cmd_valid", 64'(bus.m_rd_cmd_valid), 64'(0));
        checkOutput("abort_done_valid", 64'(bus.m_done_valid), 64'(0));
        checkOutput("abort_base_addr", bus.hll_base_addr, 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        return;
      end

      checkOutput("data_enable", 64'(bus.data_enable), 64'(beatsDone < beatsTotal));
      checkOutput("data_last", 64'(bus.data_last), 64'(beatsTotal > 0 && beatsDone == beatsTotal - 1));
      checkOutput("cmd_valid", 64'(bus.m_rd_cmd_valid), 64'(qa.size() != 0));
      if (qa.size() != 0 && bus.m_rd_cmd_valid) begin
        checkOutput("cmd_addr", bus.m_rd_cmd_addr, qa[0]);
        checkOutput("cmd_length", 64'(bus.m_rd_cmd_length), 64'(ql[0]));
      end
      expDone = (doneEdge >= 0) && (edgeCount >= doneEdge);
      checkOutput("done_valid", 64'(bus.m_done_valid), 64'(expDone));

      if (expDone && bus.m_done_valid) begin
        checkOutput("done_cycles", 64'(bus.m_done_cycles), 64'(doneEdge - acceptEdge));
        checkOutput("done_error", 64'(bus.m_done_error), 64'(err));
        checkOutput("base_hold", bus.hll_base_addr, dst);
        heldCycles = bus.m_done_cycles;
        bus.data_fire = 1'b0;
        bus.wr_cmd_fire = 1'b0;
        bus.wr_last_fire = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          bus.m_done_ready = 1'b0;
          @(negedge clk);
          checkOutput("done_hold_valid", 64'(bus.m_done_valid), 64'(1));
          checkOutput("done_hold_cycles", 64'(bus.m_done_cycles), 64'(heldCycles));
        end
        bus.m_done_ready = 1'b1;
        bus.data_fire    = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.m_done_ready = 1'b0;
        bus.data_fire    = 1'b0;
        checkOutput("idle_busy", 64'(bus.busy), 64'(0));
        checkOutput("idle_job_ready", 64'(bus.s_job_ready), 64'(1));
        checkOutput("idle_done_valid", 64'(bus.m_done_valid), 64'(0));
        finished = 1'b1;
      end else begin
        // Beats only flow against bursts the DMA already accepted; extra fires are stray traffic.
        if (beatsDone < beatsTotal) begin
          if (credit > 0 && $urandom_range(0, 3) != 0) begin
            bus.data_fire = 1'b1;
            credit--;
            beatsDone++;
            if (beatsDone == beatsTotal) lastEdge = edgeCount + 1;
          end else begin
            bus.data_fire = 1'b0;
          end
        end else begin
          bus.data_fire = ($urandom_range(0, 3) == 0);
        end

        if (qa.size() != 0 && cmdIdx == stallIdx && stallLeft > 0) begin
          bus.m_rd_cmd_ready = 1'b0;
          stallLeft--;
        end else begin
          bus.m_rd_cmd_ready = ($urandom_range(0, 3) != 0);
          if (bus.m_rd_cmd_ready && qa.size() != 0) begin
            credit += int'(ql[0] / 64);
            void'(qa.pop_front());
            void'(ql.pop_front());
            cmdIdx++;
          end
        end

        bus.wr_cmd_fire  = (lastEdge >= 0) && (edgeCount + 1 == lastEdge + kCmd);
        bus.wr_last_fire = (lastEdge >= 0) && (edgeCount + 1 == lastEdge + kLast);
        if (lastEdge >= 0 && doneEdge < 0)
          doneEdge = lastEdge + ((kCmd > kLast) ? kCmd : kLast) + 1;
        @(negedge clk);
      end
    end
    if (!finished) checkOutput("job_timeout", 64'(0), 64'(1));
    driveIdle();
  endtask

  initial begin
    logic [31:0] rlen;
    driveIdle();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_job_ready", 64'(bus.s_job_ready), 64'(1));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_cmd_valid", 64'(bus.m_rd_cmd_valid), 64'(0));
    checkOutput("rst_cmd_addr", bus.m_rd_cmd_addr, 64'(0));
    checkOutput("rst_cmd_length", 64'(bus.m_rd_cmd_length), 64'(0));
    checkOutput("rst_data_enable", 64'(bus.data_enable), 64'(0));
    checkOutput("rst_data_last", 64'(bus.data_last), 64'(0));
    checkOutput("rst_base_addr", bus.hll_base_addr, 64'(0));
    checkOutput("rst_done_valid", 64'(bus.m_done_valid), 64'(0));
    checkOutput("rst_done_cycles", 64'(bus.m_done_cycles), 64'(0));
    checkOutput("rst_done_error", 64'(bus.m_done_error), 64'(0));
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus({$urandom, $urandom}, 32'd256, {$urandom, $urandom}, -1, 0, 1, 2, -1);
    applyStimulus(64'h1000, 32'd10240, 64'hABCD_0000, 1, 5, 3, 0, -1);
    applyStimulus({$urandom, $urandom}, 32'd12800, {$urandom, $urandom}, 0, 5, 2, 2, -1);
    applyStimulus({$urandom, $urandom}, 32'd100, {$urandom, $urandom}, -1, 0, 0, 0, -1);
    applyStimulus({$urandom, $urandom}, 32'd0, {$urandom, $urandom}, -1, 0, 0, 0, -1);
    applyStimulus(64'h1000, 32'd10240, 64'h5555_0000, -1, 0, 1, 1, 50);
    applyStimulus({$urandom, $urandom}, 32'd128, 64'h7777_0000, -1, 0, 0, 1, -1);

    for (int j = 0; j < 10; j++) begin
      if ($urandom_range(0, 3) == 0) rlen = $urandom_range(0, 20000);
      else                           rlen = 32'(64 * $urandom_range(1, 200));
      applyStimulus({$urandom, $urandom}, rlen, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
